// File: rtl/enokida_mem_arbiter.sv
// Processor/trace arbiter onto a single-outstanding memory port (IDLE -> ADDR -> DATA).
// Define ENOKIDA_ARB_STARVE_GUARD_EN to let a starved trace requester win after STARVE_LIMIT contested losses.
module enokida_mem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    p_req_i,
    input  logic [ADDR_WIDTH-1:0]   p_addr_i,
    input  logic                    p_we_i,
    input  logic [DATA_WIDTH/8-1:0] p_be_i,
    input  logic [DATA_WIDTH-1:0]   p_wdata_i,
    output logic                    p_gnt_o,
    output logic                    p_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p_rdata_o,
    input  logic                    t_req_i,
    input  logic [ADDR_WIDTH-1:0]   t_addr_i,
    input  logic                    t_we_i,
    input  logic [DATA_WIDTH-1:0]   t_wdata_i,
    output logic                    t_gnt_o,
    output logic                    t_rvalid_o,
    output logic [DATA_WIDTH-1:0]   t_rdata_o,
    output logic                    m_req_o,
    output logic [ADDR_WIDTH-1:0]   m_addr_o,
    output logic                    m_we_o,
    output logic [DATA_WIDTH/8-1:0] m_be_o,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    input  logic                    m_gnt_i,
    input  logic                    m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i,
    output logic                    busy_o
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                r_state;
    logic                  r_owner_t;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [BE_WIDTH-1:0]   r_be;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic w_any_req;
    logic w_trace_wins;
    logic w_in_addr;
    logic w_hs;
    logic w_resp;

    assign w_any_req = p_req_i | t_req_i;

`ifdef ENOKIDA_ARB_STARVE_GUARD_EN
    localparam int AGE_WIDTH = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = AGE_WIDTH'(STARVE_LIMIT);

    logic [AGE_WIDTH-1:0] r_age;
    logic                 w_starved;

    assign w_starved    = (r_age == AGE_MAX);
    assign w_trace_wins = t_req_i & (~p_req_i | w_starved);

    // Age counts contested IDLE arbitrations the trace side lost; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_age <= '0;
        end else if (r_state == IDLE && t_req_i) begin
            if (w_trace_wins) begin
                r_age <= '0;
            end else if (!w_starved) begin
                r_age <= r_age + AGE_WIDTH'(1);
            end
        end
    end
`else
    assign w_trace_wins = t_req_i & ~p_req_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner_t <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state   <= ADDR;
                        r_owner_t <= w_trace_wins;
                        if (w_trace_wins) begin
                            r_addr  <= t_addr_i;
                            r_we    <= t_we_i;
                            r_be    <= '1;
                            r_wdata <= t_wdata_i;
                        end else begin
                            r_addr  <= p_addr_i;
                            r_we    <= p_we_i;
                            r_be    <= p_be_i;
                            r_wdata <= p_wdata_i;
                        end
                    end
                end
                ADDR: begin
                    if (m_gnt_i) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (m_rvalid_i) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Grant and response are same-cycle pass-throughs, qualified by the registered owner.
    assign w_in_addr  = (r_state == ADDR);
    assign w_hs       = w_in_addr & m_gnt_i;
    assign w_resp     = (r_state == DATA) & m_rvalid_i;

    assign m_req_o    = w_in_addr;
    assign m_addr_o   = w_in_addr ? r_addr  : '0;
    assign m_we_o     = w_in_addr & r_we;
    assign m_be_o     = w_in_addr ? r_be    : '0;
    assign m_wdata_o  = w_in_addr ? r_wdata : '0;
    assign busy_o     = (r_state != IDLE);

    assign p_gnt_o    = w_hs & ~r_owner_t;
    assign t_gnt_o    = w_hs & r_owner_t;
    assign p_rvalid_o = w_resp & ~r_owner_t;
    assign t_rvalid_o = w_resp & r_owner_t;
    assign p_rdata_o  = p_rvalid_o ? m_rdata_i : '0;
    assign t_rdata_o  = t_rvalid_o ? m_rdata_i : '0;

endmodule

// File: tb/tb_enokida_mem_arbiter.sv
// Randomized scoreboard bench for enokida_mem_arbiter with a protocol-level reference model.
module tb_enokida_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LIMIT = 2;
    localparam int PH_IDLE = 0;
    localparam int PH_ADDR = 1;
    localparam int PH_DATA = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [3:0]    be;
        logic [DW-1:0] wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p_req_i = 1'b0, p_we_i = 1'b0, t_req_i = 1'b0, t_we_i = 1'b0;
    logic [AW-1:0] p_addr_i = '0, t_addr_i = '0;
    logic [3:0]    p_be_i = '0;
    logic [DW-1:0] p_wdata_i = '0, t_wdata_i = '0;
    logic          p_gnt_o, p_rvalid_o, t_gnt_o, t_rvalid_o;
    logic [DW-1:0] p_rdata_o, t_rdata_o;
    logic          m_req_o, m_we_o, busy_o;
    logic [AW-1:0] m_addr_o;
    logic [3:0]    m_be_o;
    logic [DW-1:0] m_wdata_o;
    logic          m_gnt_i = 1'b0, m_rvalid_i = 1'b0;
    logic [DW-1:0] m_rdata_i = '0;

    int   checks = 0;
    int   errors = 0;
    bit   resp_manual = 1'b0;

    txn_t p_q[$];
    txn_t t_q[$];
    txn_t cur;
    bit   cur_t = 1'b0;
    bit   win_t;
    bit   exp_g, exp_r;
    int   phase = PH_IDLE;
    int   losses = 0;

    enokida_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .p_req_i(p_req_i), .p_addr_i(p_addr_i), .p_we_i(p_we_i), .p_be_i(p_be_i),
        .p_wdata_i(p_wdata_i), .p_gnt_o(p_gnt_o), .p_rvalid_o(p_rvalid_o), .p_rdata_o(p_rdata_o),
        .t_req_i(t_req_i), .t_addr_i(t_addr_i), .t_we_i(t_we_i), .t_wdata_i(t_wdata_i),
        .t_gnt_o(t_gnt_o), .t_rvalid_o(t_rvalid_o), .t_rdata_o(t_rdata_o),
        .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_we_o(m_we_o), .m_be_o(m_be_o),
        .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Reference model: bus phase, trace loss count, and who owns the current transaction.
    always @(negedge clk) begin
        if (rst) begin
            phase  = PH_IDLE;
            losses = 0;
            p_q.delete();
            t_q.delete();
        end else begin
            chk("m_req_o", m_req_o, phase == PH_ADDR);
            chk("busy_o", busy_o, phase != PH_IDLE);
            if (phase == PH_ADDR) begin
                chk("m_addr_o", m_addr_o, cur.addr);
                chk("m_we_o", m_we_o, cur.we);
                chk("m_be_o", m_be_o, cur.be);
                chk("m_wdata_o", m_wdata_o, cur.wdata);
            end else begin
                chk("m_fields_idle", {m_addr_o, m_we_o, m_be_o, m_wdata_o}, 64'h0);
            end
            exp_g = (phase == PH_ADDR) && m_gnt_i;
            exp_r = (phase == PH_DATA) && m_rvalid_i;
            chk("p_gnt_o", p_gnt_o, exp_g && !cur_t);
            chk("t_gnt_o", t_gnt_o, exp_g && cur_t);
            chk("p_rvalid_o", p_rvalid_o, exp_r && !cur_t);
            chk("t_rvalid_o", t_rvalid_o, exp_r && cur_t);
            chk("p_rdata_o", p_rdata_o, (exp_r && !cur_t) ? m_rdata_i : 32'h0);
            chk("t_rdata_o", t_rdata_o, (exp_r && cur_t) ? m_rdata_i : 32'h0);
            case (phase)
                PH_IDLE: begin
                    if (p_req_i || t_req_i) begin
                        if (p_req_i && t_req_i) begin
`ifdef ENOKIDA_ARB_STARVE_GUARD_EN
                            win_t = (losses >= LIMIT);
`else
                            win_t = 1'b0;
`endif
                            if (win_t) losses = 0;
                            else if (losses < LIMIT) losses++;
                        end else begin
                            win_t = t_req_i;
                            if (win_t) losses = 0;
                        end
                        cur_t = win_t;
                        if (win_t ? (t_q.size() == 0) : (p_q.size() == 0)) begin
                            timeout("scoreboard_empty");
                        end else begin
                            cur = win_t ? t_q.pop_front() : p_q.pop_front();
                        end
                        phase = PH_ADDR;
                    end
                end
                PH_ADDR: if (m_gnt_i) phase = PH_DATA;
                default: if (m_rvalid_i) phase = PH_IDLE;
            endcase
        end
    end

    // Random memory responder; grant/response noise outside their phases must be ignored.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!resp_manual) begin
                m_gnt_i    = 1'($urandom);
                m_rvalid_i = 1'($urandom);
                m_rdata_i  = $urandom;
            end
        end
    end

    task automatic do_txn(input bit is_t, input logic [AW-1:0] a, input logic w,
                          input logic [3:0] b, input logic [DW-1:0] d);
        txn_t x;
        int   n;
        bit   seen;
        x.addr = a; x.we = w; x.be = is_t ? 4'hF : b; x.wdata = d;
        if (is_t) begin
            t_q.push_back(x);
            t_addr_i = a; t_we_i = w; t_wdata_i = d; t_req_i = 1'b1;
        end else begin
            p_q.push_back(x);
            p_addr_i = a; p_we_i = w; p_be_i = b; p_wdata_i = d; p_req_i = 1'b1;
        end
        n = 0; seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            seen = is_t ? t_gnt_o : p_gnt_o;
        end
        if (!seen) timeout(is_t ? "t_gnt_wait" : "p_gnt_wait");
        @(posedge clk);
        #1;
        // Drop the request and scramble fields: the DUT must work from its latched copy.
        if (is_t) begin
            t_req_i = 1'b0; t_addr_i = AW'($urandom); t_wdata_i = $urandom;
        end else begin
            p_req_i = 1'b0; p_addr_i = AW'($urandom); p_wdata_i = $urandom;
        end
        if (seen) begin
            n = 0; seen = 1'b0;
            while (!seen && n < 400) begin
                @(negedge clk);
                n++;
                seen = is_t ? t_rvalid_o : p_rvalid_o;
            end
            if (!seen) timeout(is_t ? "t_rvalid_wait" : "p_rvalid_wait");
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit is_t, input int count);
        int gap;
        for (int i = 0; i < count; i++) begin
            do_txn(is_t, AW'($urandom), 1'($urandom), 4'($urandom), $urandom);
            if (is_t) gap = $urandom_range(0, 4);
            else gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic mem_serve(input int gap, input logic [DW-1:0] d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_req_o && n < 100);
        if (!m_req_o) begin
            timeout("mem_serve_req");
        end else begin
            repeat (gap) @(posedge clk);
            @(posedge clk); #1;
            m_gnt_i = 1'b1;
            @(posedge clk); #1;
            m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = d;
            @(posedge clk); #1;
            m_rvalid_i = 1'b0; m_rdata_i = '0;
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {m_req_o, busy_o, p_gnt_o, t_gnt_o, p_rvalid_o, t_rvalid_o, m_we_o, m_be_o, m_addr_o}, 64'h0);
        chk({nm, "_data"}, {p_rdata_o, t_rdata_o}, 64'h0);
        chk({nm, "_wdata"}, m_wdata_o, 64'h0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_outputs");
        rst = 1'b0;

        fork
            drive(1'b0, 40);
            drive(1'b1, 25);
        join

        @(posedge clk); #1;
        resp_manual = 1'b1;
        m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0;
        fork
            do_txn(1'b0, 16'h0040, 1'b0, 4'hF, 32'h0);
            mem_serve(0, 32'hDEADBEEF);
        join
        fork
            do_txn(1'b1, 16'h0100, 1'b1, 4'h0, 32'h12345678);
            mem_serve(5, 32'h0);
        join

        // Abandon a transaction in DATA with an asynchronous reset.
        p_q.push_back('{addr: 16'h0080, we: 1'b0, be: 4'hF, wdata: 32'h0});
        p_addr_i = 16'h0080; p_we_i = 1'b0; p_be_i = 4'hF; p_wdata_i = '0; p_req_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_req_o && n < 100);
        if (!m_req_o) timeout("rst_test_req");
        @(posedge clk); #1;
        m_gnt_i = 1'b1;
        @(posedge clk); #1;
        m_gnt_i = 1'b0; p_req_i = 1'b0;
        chk("busy_before_rst", busy_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst_outputs");
        @(posedge clk); #1;
        rst = 1'b0;
        m_rvalid_i = 1'b1; m_rdata_i = 32'hCAFEF00D; m_gnt_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("late_rvalid_ignored", {p_rvalid_o, t_rvalid_o, p_rdata_o, t_rdata_o}, 64'h0);
        end
        @(posedge clk); #1;
        m_rvalid_i = 1'b0; m_gnt_i = 1'b0; m_rdata_i = '0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
